mmio_uart_tx: RTL
=================

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter BASE_ADDR, default 32'h1000_0000, is the word-aligned base of the peripheral's register window.
REQ-002 Parameter CLK_DIV, default 868, gives the clock cycles per UART bit (100 MHz / 115200); legal range is 2 or more.
REQ-003 Parameter FIFO_DEPTH, default 4, gives the transmit FIFO entries; legal values are powers of two, 2 to 16.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 mem_write  input  1  store strobe from the core, valid for one cycle.
REQ-007 mem_read  input  1  load strobe from the core.
REQ-008 addr  input  32  byte address from the core ALU output.
REQ-009 write_data  input  32  store data after store addressing; only [7:0] is used by TXDATA.
REQ-010 read_data  output  32  register read value; combinational from addr.
REQ-011 hit  output  1  high when addr[31:4] equals BASE_ADDR[31:4]; the top level uses it to mux read_data and to gate the data memory write.
REQ-012 uart_tx  output  1  serial line output; idle level is high.

Function
REQ-013 Register map: BASE+0x0 is TXDATA (write-only, reads 0). BASE+0x4 is STATUS (read). Any other offset in the window reads 0 and ignores writes.
REQ-014 STATUS layout: [0] busy (FSM not IDLE); [1] full; [2] empty; [3] overflow (sticky); [8:4] count; all other bits 0.
REQ-015 A write to TXDATA with hit=1 pushes write_data[7:0] into the FIFO at that edge, unless the FIFO is full.
REQ-016 A push while the FIFO is full and no pop occurs in the same cycle drops the byte and sets overflow.
REQ-017 A push and a pop in the same cycle both take effect; count is unchanged, including when the FIFO is full.
REQ-018 Any write to STATUS with hit=1 clears overflow; this takes priority over a same-cycle overflow set.
REQ-019 read_data equals the selected register whenever hit=1 and mem_read=1; otherwise it is 0.
REQ-020 FSM states are IDLE, START, DATA and STOP.
REQ-021 IDLE: when the FIFO is non-empty, pop the head into the shift register, clear the bit counter and baud counter, and go to START; uart_tx=1 while in IDLE.
REQ-022 START drives uart_tx=0 for CLK_DIV cycles, then goes to DATA.
REQ-023 DATA drives shift[0] (LSB first) for CLK_DIV cycles per bit, shifting after each bit; after 8 bits it goes to STOP.
REQ-024 STOP drives uart_tx=1 for CLK_DIV cycles, then goes to IDLE.
REQ-025 A byte written at edge N with an empty FIFO in IDLE is popped at edge N+1; the start bit appears at uart_tx after edge N+1.
REQ-026 A frame is exactly 10*CLK_DIV cycles; back-to-back bytes add one IDLE cycle between frames.
REQ-027 The baud counter counts 0..CLK_DIV-1 and wraps, and is cleared on every state entry.
REQ-028 FIFO pointers are log2(FIFO_DEPTH) bits and wrap; count is log2(FIFO_DEPTH)+1 bits.
REQ-029 uart_tx is driven from a register, with no combinational path to any input.

Reset
REQ-030 While reset=1 at an edge: FSM=IDLE, uart_tx=1, FIFO empty (pointers and count 0), overflow=0, and shift, bit and baud counters are 0.
REQ-031 Reset asserted mid-frame aborts the frame; uart_tx is high from the following cycle and all queued bytes are discarded.
REQ-032 Writes during reset are ignored.

Structure
REQ-033 Package riscv_mmio_pkg holds the UART_TXDATA_OFS and UART_STATUS_OFS constants, the STATUS bit indices and the uart_tx_state_t enum.
REQ-034 The FIFO is a sub-module, sync_fifo (parameters WIDTH and DEPTH; push, pop, full, empty, count); the FSM and register decode stay in mmio_uart_tx.

Verification (CLK_DIV=4, FIFO_DEPTH=4)
REQ-035 Write 0x55 to BASE+0 -> uart_tx reads 0, then 1,0,1,0,1,0,1,0, then 1, each held 4 cycles; total 40 cycles; busy returns to 0.
REQ-036 Write 6 bytes back-to-back while idle -> the first is popped, the next 4 fill the FIFO, the 6th is dropped; STATUS reads full=1 and overflow=1.
REQ-037 Then write STATUS -> overflow=0; exactly 5 frames are observed on uart_tx.
REQ-038 Fill the FIFO and push on the same cycle as a pop -> the byte is accepted, count stays 4 and overflow=0.
REQ-039 Assert reset during the 3rd data bit -> uart_tx=1 from the next cycle; STATUS reads 0x4 (empty); no further frame is sent.
REQ-040 Read BASE+0x8 and read addr BASE+0x10 -> read_data=0; hit=1 for the first and hit=0 for the second.

Source files
------------

// File: rtl/riscv_mmio_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and the transmit FSM state type.
package riscv_mmio_pkg;

    localparam logic [3:0] UART_TXDATA_OFS = 4'h0;
    localparam logic [3:0] UART_STATUS_OFS = 4'h4;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;
    localparam int STAT_CNT_MSB = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrapping pointers and an occupancy counter; a push
// into a full FIFO is accepted only when a pop frees the head in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // NOTE: the storage array is deliberately not reset; pointers and count decide which entries are valid, and an unreset array can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS register window in front
// of a byte FIFO, drained by a START/DATA/STOP serialiser with a registered line.
module mmio_uart_tx
    import riscv_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          CLK_DIV    = 868,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        hit,
    output logic        uart_tx
);

    localparam int BW = $clog2(CLK_DIV);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    uart_tx_state_t state_q, state_d;
    logic [BW-1:0]  baud_q, baud_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic           tx_q, tx_d;
    logic           ovf_q, ovf_d;

    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [7:0]     fifo_head;
    logic [CW-1:0]  fifo_count;

    logic           wr_txdata;
    logic           wr_status;
    logic           baud_last;
    logic [31:0]    status;
    logic           unused_wdata;

    assign unused_wdata = ^write_data[31:8];

    assign hit       = (addr[31:4] == BASE_ADDR[31:4]);
    assign wr_txdata = mem_write && hit && (addr[3:0] == UART_TXDATA_OFS);
    assign wr_status = mem_write && hit && (addr[3:0] == UART_STATUS_OFS);
    assign baud_last = (baud_q == BW'(CLK_DIV - 1));
    assign uart_tx   = tx_q;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (wr_txdata),
        .din_i   (write_data[7:0]),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // NOTE: every signal written in this block gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_last ? '0 : baud_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        ovf_d    = ovf_q;

        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    bit_d    = '0;
                    state_d  = ST_START;
                end
            end
            ST_START: if (baud_last) state_d = ST_DATA;
            ST_DATA: begin
                if (baud_last) begin
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 1'b1;
                    end
                end
            end
            ST_STOP:  if (baud_last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Line level follows the state being entered, so the pin is a pure flop.
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase

        if (wr_txdata && fifo_full && !fifo_pop) ovf_d = 1'b1;
        if (wr_status)                           ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        status                            = '0;
        status[STAT_BUSY]                 = (state_q != ST_IDLE);
        status[STAT_FULL]                 = fifo_full;
        status[STAT_EMPTY]                = fifo_empty;
        status[STAT_OVF]                  = ovf_q;
        status[STAT_CNT_MSB:STAT_CNT_LSB] = 5'(fifo_count);
    end

    always_comb begin
        read_data = '0;
        if (hit && mem_read && (addr[3:0] == UART_STATUS_OFS)) read_data = status;
    end

endmodule
